pkt_rr_arbiter_528b: RTL and testbench
======================================

// Module: pkt_rr_arbiter_528b
// PURPOSE
//  Packet-aware round-robin arbiter sharing one 528b register FIFO (4-deep) between NUM_REQ flit sources.
//  - Holds the grant from the first flit to the tail flit, so packets are never interleaved in the FIFO.
//  - Drives the FIFO write side directly.
//  - A watchdog releases a grant held by a source that stalls mid-packet.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  DATA_W       528   flit width; bit DATA_W-1 is the tail (end-of-packet) flag
//  TIMEOUT_CYC  255   idle cycles mid-packet before the grant is revoked (1..255)
// PORTS
//  clk            in   1               system clock
//  rst_n          in   1               asynchronous, active-low reset
//  req_valid      in   NUM_REQ         per-source flit valid
//  req_data       in   NUM_REQ*DATA_W  per-source flit; source i in slice [i*DATA_W +: DATA_W]
//  req_ready      out  NUM_REQ         per-source flit accepted this cycle
//  fifo_wr_en     out  1               FIFO write enable
//  fifo_din       out  DATA_W          FIFO write data
//  fifo_full      in   1               FIFO full
//  grant          out  NUM_REQ         one-hot current owner; 0 when idle
//  busy           out  1               packet in progress (state BUSY)
//  timeout_pulse  out  1               one-cycle pulse when the watchdog revokes a grant
// BEHAVIOUR
//  Reset
//   - Async on rst_n low: state=IDLE, grant=0, rr_ptr=0, idle_cnt=0, timeout_pulse=0.
//   - Combinational outputs read 0 while in reset (req_ready, fifo_wr_en, fifo_din).
//   - Reset mid-packet drops the packet; the FIFO contents are not touched.
//  FSM: IDLE, BUSY
//   - IDLE:
//     - If any req_valid: grant <= first valid source searching from rr_ptr upward (wrap at NUM_REQ-1->0).
//     - Enter BUSY and clear idle_cnt.
//     - No flit is accepted in IDLE: one bubble cycle per packet.
//   - BUSY:
//     - Flit accept (g = owner) is combinational: acc = req_valid[g] & ~fifo_full.
//     - On acc: req_ready[g]=1, fifo_wr_en=1, fifo_din=req_data[g].
//     - All other req_ready are 0.
//     - fifo_din = 0 whenever fifo_wr_en=0.
//     - On acc with tail bit set: state=IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ, next cycle.
//   - Watchdog:
//     - In BUSY, idle_cnt increments on each cycle with req_valid[g]=0.
//     - idle_cnt clears on acc.
//     - idle_cnt holds while valid is blocked by fifo_full; back-pressure is never a timeout.
//     - When idle_cnt==TIMEOUT_CYC:
//       - timeout_pulse=1 for one cycle;
//       - state=IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ;
//       - the partial packet stays in the FIFO without a tail; the consumer handles it.
//  Boundary conditions
//   - Single-flit packet (tail on first flit): IDLE->BUSY->IDLE, one write.
//   - FIFO full: acc=0, the flit is held by the source, grant is kept.
//   - Tail accept while another source is valid: that source is granted in the following IDLE cycle.
//   - req_valid dropping in IDLE before the grant is taken is harmless.
//   - req_valid of non-owners is ignored in BUSY.
//   - rr_ptr wraps NUM_REQ-1 -> 0.
//   - idle_cnt is 8 bits and saturates at TIMEOUT_CYC.
//  Latency
//   - Request to first write: 1 cycle.
//   - Steady-state throughput: 1 flit/cycle while not full.
// TESTING
//  1. Reset:
//     - Stimulus: assert rst_n=0 mid-packet.
//     - Required: grant=0, busy=0, fifo_wr_en=0 immediately (asynchronous); after release, the next request is granted from src0.
//  2. Round-robin:
//     - Stimulus: all 4 sources each send 2-flit packets continuously.
//     - Required: grant order 0,1,2,3,0; 8 writes per round; one bubble between packets; no interleaving.
//  3. Back-pressure:
//     - Stimulus: src1 3-flit packet, fifo_full=1 for 10 cycles mid-packet.
//     - Required: no writes, req_ready=0, no timeout_pulse; completes after full drops.
//  4. Timeout:
//     - Stimulus: src2 sends a head flit, then req_valid=0 (TIMEOUT_CYC=4).
//     - Required: timeout_pulse on the 4th idle cycle, then IDLE; src3 granted next.
//  5. Single-flit packets:
//     - Stimulus: src0 and src3 send tail-only flits together.
//     - Required: src0 written first, src3 second, rr_ptr=0 afterward.

Source files
------------

// File: rtl/pkt_rr_arbiter_528b.sv
// Packet-aware round-robin arbiter: one owner at a time writes whole packets into a shared FIFO.
// Latency: one grant bubble per packet, then flits pass combinationally at 1/cycle.
// Backpressure: fifo_full stalls the owner without releasing the grant and never feeds the watchdog.
module pkt_rr_arbiter_528b #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 528,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic                      fifo_full,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_pulse
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [7:0]       TO_MAX  = 8'(TIMEOUT_CYC);
    localparam logic [7:0]       TO_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   owner_q, rr_ptr_q, pick_idx, next_ptr;
    logic [7:0]         idle_cnt_q;
    logic               timeout_q;
    logic [DATA_W-1:0]  owner_dat;
    logic               pick_vld, owner_vld, acc, pkt_end, idle_cyc, wd_expire, release_g;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Lowest offset from rr_ptr wins, so scan offsets from high to low.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr_q, k)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        owner_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) owner_dat = req_data[i*DATA_W +: DATA_W];
        end
        owner_vld = req_valid[owner_q];
        acc       = (state_q == BUSY) & owner_vld & ~fifo_full;
        pkt_end   = acc & owner_dat[DATA_W-1];
        idle_cyc  = (state_q == BUSY) & ~owner_vld;
        wd_expire = idle_cyc & (idle_cnt_q == TO_LAST);
        release_g = pkt_end | wd_expire;
        next_ptr  = (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = BUSY;
            BUSY:    if (release_g) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q == BUSY);
        grant         = grant_q;
        timeout_pulse = timeout_q;
        fifo_wr_en    = acc;
        fifo_din      = acc ? owner_dat : '0;
        req_ready     = acc ? grant_q : '0;
    end

    // Idle counter stays at TIMEOUT_CYC after a revoke until the next grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= wd_expire;
            if (state_q == IDLE) begin
                if (pick_vld) begin
                    grant_q    <= NUM_REQ'(1) << pick_idx;
                    owner_q    <= pick_idx;
                    idle_cnt_q <= '0;
                end
            end else begin
                if (acc)
                    idle_cnt_q <= '0;
                else if (idle_cyc && idle_cnt_q != TO_MAX)
                    idle_cnt_q <= idle_cnt_q + 8'd1;
                if (release_g) begin
                    grant_q  <= '0;
                    rr_ptr_q <= next_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_pkt_rr_arbiter_528b.sv
// Bench for pkt_rr_arbiter_528b: directed scenarios plus randomized packet traffic,
// compared every cycle against a queue-based model of the arbitration rules.
module tb_pkt_rr_arbiter_528b;
    localparam int N  = 4;
    localparam int DW = 528;
    localparam int TO = 4;
    typedef logic [DW-1:0] flit_t;

    logic            clk, rst_n;
    logic [N-1:0]    req_valid, req_ready, grant;
    logic [N*DW-1:0] req_data;
    logic            fifo_wr_en, fifo_full, busy, timeout_pulse;
    flit_t           fifo_din;

    pkt_rr_arbiter_528b #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .fifo_full(fifo_full), .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int     checks = 0;
    int     failures = 0;
    flit_t  srcq [N][$];
    logic [N-1:0] src_en;
    logic [N-1:0] acc_pend;
    bit     m_busy, m_to;
    int     m_owner, m_ptr, m_cnt;
    int     cyc, wr_count, to_count, first_wr_cyc, to_cyc;
    int     grant_log[$];
    logic [N-1:0] prev_grant;

    task automatic check(input string name, input flit_t act, input flit_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic budget_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: cycle budget expired before completion", name);
    endtask

    function automatic flit_t rnd_flit();
        logic [32*((DW+31)/32)-1:0] t;
        for (int w = 0; w < (DW+31)/32; w++) t[w*32 +: 32] = $urandom();
        return t[DW-1:0];
    endfunction

    function automatic flit_t mk_flit(input bit tail);
        flit_t f;
        f = rnd_flit();
        f[DW-1] = tail;
        return f;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push_pkt(input int s, input int len);
        for (int j = 0; j < len; j++) srcq[s].push_back(mk_flit(j == len - 1));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && srcq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*DW +: DW] = srcq[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = rnd_flit();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc_pend[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        drive();
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic clear_obs();
        wr_count = 0;
        to_count = 0;
        first_wr_cyc = -1;
        to_cyc = -1;
        grant_log.delete();
    endtask

    // Reference: one owner per packet, chosen round-robin; a write happens whenever the owner is valid and the FIFO has room.
    task automatic model_cycle();
        logic [N-1:0] egrant, eready;
        flit_t d_own, edin;
        bit acc, found;
        int idx;
        cyc++;
        d_own  = req_data[m_owner*DW +: DW];
        acc    = m_busy && req_valid[m_owner] && !fifo_full;
        egrant = m_busy ? (N'(1) << m_owner) : '0;
        eready = acc ? egrant : '0;
        edin   = acc ? d_own : '0;
        check("grant", grant, egrant);
        check("busy", busy, m_busy);
        check("req_ready", req_ready, eready);
        check("fifo_wr_en", fifo_wr_en, acc);
        check("fifo_din", fifo_din, edin);
        check("timeout_pulse", timeout_pulse, m_to);
        if (fifo_wr_en) begin
            wr_count++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (timeout_pulse) begin
            to_count++;
            to_cyc = cyc;
        end
        if (prev_grant == '0 && grant != '0) grant_log.push_back(oh_idx(grant));
        prev_grant = grant;
        acc_pend = eready;
        m_to = 1'b0;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    m_owner = idx;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_cnt = 0;
            end
        end else if (acc) begin
            m_cnt = 0;
            if (d_own[DW-1]) begin
                m_busy = 1'b0;
                m_ptr = (m_owner + 1) % N;
            end
        end else if (!req_valid[m_owner]) begin
            m_cnt++;
            if (m_cnt == TO) begin
                m_to = 1'b1;
                m_busy = 1'b0;
                m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_to = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
                acc_pend = '0;
                prev_grant = '0;
            end else begin
                model_cycle();
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(all_empty() && !m_busy) && n < budget);
        if (!(all_empty() && !m_busy)) budget_fail(name);
    endtask

    task automatic wait_write(input string name, input int budget);
        int n = 0;
        while (wr_count == 0 && n < budget) begin
            step();
            n++;
        end
        if (wr_count == 0) budget_fail(name);
    endtask

    task automatic check_order(input string name, input int n, input int exp[8]);
        check({name, "_count"}, grant_log.size(), n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", name, i), (i < grant_log.size()) ? grant_log[i] : -1, exp[i]);
    endtask

    initial begin
        int stall[N];
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        fifo_full = 1'b0;
        src_en = '1;
        acc_pend = '0;
        cyc = 0;
        prev_grant = '0;
        m_busy = 1'b0; m_to = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) stall[i] = 0;
        clear_obs();
        fork
            monitor();
        join_none

        // Reset state.
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_ready", req_ready, 0);
        check("rst_din", fifo_din, 0);
        check("rst_timeout", timeout_pulse, 0);
        req_valid = '0;
        rst_n = 1'b1;

        // Round-robin: two 2-flit packets per source.
        clear_obs();
        for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) push_pkt(s, 2);
        drive();
        drain("rr_drain", 200);
        check_order("rr_order", 8, '{0, 1, 2, 3, 0, 1, 2, 3});
        check("rr_writes", wr_count, 16);
        check("rr_span", cyc - first_wr_cyc, 22);

        // Back-pressure mid-packet on src1.
        clear_obs();
        push_pkt(1, 3);
        drive();
        wait_write("bp_first", 20);
        fifo_full = 1'b1;
        repeat (10) step();
        check("bp_writes_held", wr_count, 1);
        check("bp_no_timeout", to_count, 0);
        check("bp_grant_kept", grant, 4'b0010);
        check("bp_ready_low", req_ready, 0);
        fifo_full = 1'b0;
        drain("bp_drain", 50);
        check("bp_writes", wr_count, 3);
        check("bp_timeout_total", to_count, 0);

        // Watchdog: src2 stalls after its head flit, src3 waits.
        clear_obs();
        srcq[2].push_back(mk_flit(1'b0));
        push_pkt(3, 1);
        drive();
        drain("to_drain", 100);
        check("to_count", to_count, 1);
        check("to_delay", to_cyc - first_wr_cyc, 5);
        check_order("to_order", 2, '{2, 3, 0, 0, 0, 0, 0, 0});
        check("to_writes", wr_count, 2);

        // Single-flit packets from src0 and src3 together, then a pointer probe.
        clear_obs();
        push_pkt(0, 1);
        push_pkt(3, 1);
        drive();
        drain("sf_drain", 50);
        check_order("sf_order", 2, '{0, 3, 0, 0, 0, 0, 0, 0});
        check("sf_writes", wr_count, 2);
        clear_obs();
        push_pkt(1, 1);
        push_pkt(3, 1);
        drive();
        drain("ptr_drain", 50);
        check_order("ptr_order", 2, '{1, 3, 0, 0, 0, 0, 0, 0});

        // Asynchronous reset mid-packet with rr_ptr away from 0.
        clear_obs();
        push_pkt(1, 1);
        drive();
        drain("pre_rst_drain", 50);
        clear_obs();
        push_pkt(2, 3);
        drive();
        wait_write("mid_first", 20);
        check("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 0);
        check("arst_busy", busy, 0);
        check("arst_wr_en", fifo_wr_en, 0);
        check("arst_ready", req_ready, 0);
        check("arst_din", fifo_din, 0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_obs();
        push_pkt(0, 1);
        push_pkt(3, 1);
        drive();
        drain("post_rst_drain", 50);
        check_order("post_rst_order", 2, '{0, 3, 0, 0, 0, 0, 0, 0});

        // Randomized traffic with source stalls and FIFO back-pressure.
        clear_obs();
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 3 && $urandom_range(0, 7) == 0) push_pkt(i, $urandom_range(1, 4));
                if (stall[i] > 0) stall[i]--;
                else if ($urandom_range(0, 19) == 0) stall[i] = $urandom_range(1, 6);
                src_en[i] = (stall[i] == 0);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            drive();
        end
        src_en = '1;
        fifo_full = 1'b0;
        drive();
        drain("rand_drain", 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
